// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: operand, compressor and result signals of booth_mul_arbiter.
//   req0_*/req1_* : two operand channels (valid/ready, 7-bit signed a, 8-bit signed b)
//   c, e..h       : negate bits and four partial products driven to the compressor
//   vs, vc        : carry-save sum/carry returned combinationally by the compressor
//   out_*         : tagged 16-bit product with valid/ready backpressure
// The slave modport is the arbiter; master is the surrounding environment.
interface booth_mul_arbiter_if;
  localparam int unsigned A_W  = 7;
  localparam int unsigned B_W  = 8;
  localparam int unsigned PP_W = 8;
  localparam int unsigned ND   = 4;
  localparam int unsigned CS_W = 17;
  localparam int unsigned P_W  = 16;

  logic            req0_valid;
  logic            req0_ready;
  logic [A_W-1:0]  req0_a;
  logic [B_W-1:0]  req0_b;
  logic            req1_valid;
  logic            req1_ready;
  logic [A_W-1:0]  req1_a;
  logic [B_W-1:0]  req1_b;
  logic [ND-1:0]   c;
  logic [PP_W-1:0] e;
  logic [PP_W-1:0] f;
  logic [PP_W-1:0] g;
  logic [PP_W-1:0] h;
  logic [CS_W-1:0] vs;
  logic [CS_W-1:0] vc;
  logic            out_valid;
  logic            out_ready;
  logic            out_id;
  logic [P_W-1:0]  out_p;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  vs, vc, out_ready,
    output req0_ready, req1_ready,
    output c, e, f, g, h,
    output out_valid, out_id, out_p
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output vs, vc, out_ready,
    input  req0_ready, req1_ready,
    input  c, e, f, g, h,
    input  out_valid, out_id, out_p
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin two-channel scheduler for the shared radix-4
// Booth partial-product compressor. Grants one operand pair per cycle into an
// operand latch (S1), drives the compressor from S1, and registers the resolved
// carry-save result with its channel tag in the output stage (S2).
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : booth_mul_arbiter_if.slave (operand channels, compressor, result)
module booth_mul_arbiter (
  input logic                 clk,
  input logic                 rst,
  booth_mul_arbiter_if.slave  bus
);

  localparam int unsigned A_W  = 7;
  localparam int unsigned B_W  = 8;
  localparam int unsigned PP_W = 8;
  localparam int unsigned ND   = 4;
  localparam int unsigned P_W  = 16;

  // Operand latch
  logic           s1_v;
  logic           s1_id;
  logic [A_W-1:0] s1_a;
  logic [B_W-1:0] s1_b;

  // Output register
  logic           out_valid_q;
  logic           out_id_q;
  logic [P_W-1:0] out_p_q;

  // Round-robin pointer: id of the most recent grant
  logic           last;

  logic           advance;
  logic           gnt0;
  logic           gnt1;
  logic           grant_any;

  logic [ND-1:0]   neg;
  logic [PP_W-1:0] pp [ND];

  // Arbitration: on a tie the channel not granted last wins; grant only when S1 can move
  always_comb begin
    advance   = ~out_valid_q | bus.out_ready;
    gnt0      = advance & bus.req0_valid & (~bus.req1_valid | last);
    gnt1      = advance & bus.req1_valid & (~bus.req0_valid | ~last);
    grant_any = gnt0 | gnt1;
  end

  // Pipeline registers: S2 takes S1, S1 takes the granted channel, both hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v        <= 1'b0;
      s1_id       <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_p_q     <= '0;
      last        <= 1'b1;
    end else if (advance) begin
      out_valid_q <= s1_v;
      out_id_q    <= s1_id;
      if (s1_v) begin
        out_p_q <= P_W'(bus.vs + bus.vc);
      end
      s1_v <= grant_any;
      if (grant_any) begin
        s1_id <= gnt1;
        s1_a  <= gnt1 ? bus.req1_a : bus.req0_a;
        s1_b  <= gnt1 ? bus.req1_b : bus.req0_b;
        last  <= gnt1;
      end
    end
  end

  // Radix-4 Booth recoding of the latched multiplier; drives are zero when S1 is empty.
  // A negative digit is sent as the one's complement plus a carry-in on c[i].
  always_comb begin
    logic [B_W:0]    b_ext;
    logic [2:0]      t;
    logic [PP_W-1:0] mag;
    b_ext = {s1_b, 1'b0};
    t     = '0;
    mag   = '0;
    neg   = '0;
    for (int i = 0; i < ND; i++) begin
      t = b_ext[2*i +: 3];
      case (t)
        3'b000, 3'b111: mag = '0;
        3'b011, 3'b100: mag = {s1_a, 1'b0};
        default:        mag = {s1_a[A_W-1], s1_a};
      endcase
      neg[i] = s1_v & t[2] & ~(t[1] & t[0]);
      pp[i]  = s1_v ? (neg[i] ? ~mag : mag) : '0;
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.c          = neg;
  assign bus.e          = pp[0];
  assign bus.f          = pp[1];
  assign bus.g          = pp[2];
  assign bus.h          = pp[3];
  assign bus.out_valid  = out_valid_q;
  assign bus.out_id     = out_id_q;
  assign bus.out_p      = out_p_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: self-checking bench for booth_mul_arbiter. Models the
// compressor as a plain weighted sum split randomly into sum/carry, and checks
// products against a*b, grant order against a round-robin reference, and the
// latency, stall and reset corner cases.
module tb_booth_mul_arbiter;

  logic clk;
  logic rst;
  logic [16:0] split;

  booth_mul_arbiter_if bus ();

  booth_mul_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compressor model: weighted sum of sign-extended partial products plus carry-ins
  always_comb begin
    logic [16:0] tot;
    logic [7:0]  pv [4];
    pv[0] = bus.e;
    pv[1] = bus.f;
    pv[2] = bus.g;
    pv[3] = bus.h;
    tot   = '0;
    for (int i = 0; i < 4; i++) begin
      tot = tot + ((17'($signed(pv[i])) + 17'(bus.c[i])) << (2 * i));
    end
    bus.vs = split;
    bus.vc = tot - split;
  end

  typedef struct {
    logic        id;
    logic [15:0] p;
  } exp_t;

  typedef struct {
    logic [6:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  exp_t sbq [$];
  vec_t tbl [9];

  int   n_pass;
  int   n_tot;
  logic mon_en;
  logic mlast;
  logic r0_seen;
  logic r1_seen;

  function automatic logic [15:0] prod(input logic [6:0] a, input logic [7:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return 16'(x);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic new_op0();
    bus.req0_a = 7'($urandom);
    bus.req0_b = 8'($urandom);
  endtask

  task automatic new_op1();
    bus.req1_a = 7'($urandom);
    bus.req1_b = 8'($urandom);
  endtask

  // Reference at the sampling point: expected grants and the product scoreboard
  task automatic mon();
    logic adv;
    logic e0;
    logic e1;
    r0_seen = bus.req0_ready;
    r1_seen = bus.req1_ready;
    if (!mon_en) return;
    adv = !bus.out_valid || bus.out_ready;
    e0  = adv && bus.req0_valid && (!bus.req1_valid || mlast);
    e1  = adv && bus.req1_valid && (!bus.req0_valid || !mlast);
    chk("ready", {bus.req1_ready, bus.req0_ready}, {e1, e0});
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        exp_t x;
        x = sbq.pop_front();
        chk("sb_id", bus.out_id, x.id);
        chk("sb_p", bus.out_p, x.p);
      end
    end
    if (e0 || e1) begin
      exp_t y;
      y.id = e1;
      y.p  = e1 ? prod(bus.req1_a, bus.req1_b) : prod(bus.req0_a, bus.req0_b);
      sbq.push_back(y);
      mlast = e1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    split = 17'($urandom);
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (sbq.size() != 0 || bus.out_valid) cycle();
    end
    chk("drain_sb_empty", 64'(sbq.size()), 0);
    chk("drain_out_valid", bus.out_valid, 0);
  endtask

  task automatic chk_zero_out(input string nm);
    chk({nm, "_out"}, {bus.out_valid, bus.out_id, bus.out_p}, 0);
    chk({nm, "_drv"}, {bus.c, bus.e, bus.f, bus.g, bus.h}, 0);
  endtask

  task automatic do_reset();
    mon_en         = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.out_ready  = 1'b0;
    rst            = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    sbq.delete();
    mlast  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    logic [63:0] snap_out;
    logic [63:0] snap_pp;
    logic [15:0] pa;
    n_pass = 0;
    n_tot  = 0;
    mon_en = 1'b0;
    mlast  = 1'b1;
    split  = '0;
    r0_seen = 1'b0;
    r1_seen = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk_zero_out("reset");
    do_reset();

    // Directed operand table on channel 0, one at a time
    tbl[0] = '{7'h05, 8'h03, 16'd15};
    tbl[1] = '{7'h40, 8'h80, 16'h2000};
    tbl[2] = '{7'h3F, 8'h7F, 16'h1F41};
    tbl[3] = '{7'h40, 8'h7F, 16'hE040};
    tbl[4] = '{7'h00, 8'hFF, 16'h0000};
    tbl[5] = '{7'h7F, 8'hFF, 16'h0001};
    tbl[6] = '{7'h01, 8'h80, 16'hFF80};
    tbl[7] = '{7'h40, 8'h01, 16'hFFC0};
    tbl[8] = '{7'h73, 8'hF9, 16'h005B};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.req0_valid = 1'b1;
      bus.req0_a     = tbl[k].a;
      bus.req0_b     = tbl[k].b;
      cycle();
      chk("tbl_accept", r0_seen, 1);
      bus.req0_valid = 1'b0;
      chk("tbl_lat_early", bus.out_valid, 0);
      cycle();
      chk("tbl_valid", bus.out_valid, 1);
      chk("tbl_p", bus.out_p, tbl[k].p);
      chk("tbl_id", bus.out_id, 0);
      cycle();
    end
    drain();

    // Contention from reset: strict alternation starting with channel 0
    do_reset();
    bus.out_ready  = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    new_op0();
    new_op1();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_both", r0_seen & r1_seen, 0);
      chk("rr_grant", {r1_seen, r0_seen}, (k % 2 != 0) ? 2'b10 : 2'b01);
      if (r0_seen) new_op0();
      if (r1_seen) new_op1();
    end

    // Backpressure with S1 and S2 full
    bus.out_ready = 1'b0;
    snap_out = {bus.out_valid, bus.out_id, bus.out_p};
    snap_pp  = {bus.c, bus.e, bus.f, bus.g, bus.h};
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("stall_out", {bus.out_valid, bus.out_id, bus.out_p}, snap_out);
      chk("stall_pp", {bus.c, bus.e, bus.f, bus.g, bus.h}, snap_pp);
      chk("stall_ready", {r1_seen, r0_seen}, 0);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (r0_seen) new_op0();
      if (r1_seen) new_op1();
    end
    drain();

    // Asynchronous reset with both stages occupied
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    new_op0();
    new_op1();
    bus.out_ready = 1'b1;
    cycle();
    if (r0_seen) new_op0();
    if (r1_seen) new_op1();
    bus.out_ready = 1'b0;
    cycle();
    chk("pre_rst_full", bus.out_valid, 1);
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk_zero_out("async_rst");
    @(posedge clk);
    #3;
    rst = 1'b0;
    sbq.delete();
    mlast  = 1'b1;
    mon_en = 1'b1;
    new_op0();
    new_op1();
    pa = prod(bus.req0_a, bus.req0_b);
    bus.out_ready = 1'b1;
    cycle();
    chk("post_rst_tie", {r1_seen, r0_seen}, 2'b01);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("post_rst_empty", bus.out_valid, 0);
    cycle();
    chk("post_rst_first", {bus.out_valid, bus.out_id, bus.out_p}, {1'b1, 1'b0, pa});
    drain();

    // Exhaustive sweep on channel 1
    bus.out_ready  = 1'b1;
    bus.req1_valid = 1'b1;
    for (int a = 0; a < 128; a++) begin
      for (int b = 0; b < 256; b++) begin
        bus.req1_a = 7'(a);
        bus.req1_b = 8'(b);
        cycle();
      end
    end
    drain();

    // Random traffic with random backpressure
    for (int k = 0; k < 3000; k++) begin
      if (!bus.req0_valid || r0_seen) begin
        bus.req0_valid = 1'($urandom_range(0, 1));
        new_op0();
      end
      if (!bus.req1_valid || r1_seen) begin
        bus.req1_valid = 1'($urandom_range(0, 1));
        new_op1();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
